// File: rtl/tdm_demux8_pkg.sv
// tdm_demux8_pkg: shared constants and state encoding for the TDM receive path.
// Frame length depends on TDM_DEMUX_PARITY_EN (adds one even-parity slot after the data slots).
`default_nettype none

package tdm_demux8_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = NCH + 1;
`else
  localparam int FRAME_LEN = NCH;
`endif

  localparam int SLOT_W = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_CHECK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: modulo-F slot counter with increment enable, clear-to-0,
// load-to-1 and a wrap flag raised while the count sits on the last slot.
`default_nettype none

module tdm_slot_counter #(
  parameter int F = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  input  logic         i_load1,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_wrap = (r_cnt == W'(F - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load1) begin
      r_cnt <= W'(1);
    end else if (i_inc) begin
      r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdm_demux8.sv
// tdm_demux8: TDM receive demultiplexer; locks to frame sync and presents 8 channels per frame.
// Optional TDM_DEMUX_PARITY_EN adds an even-parity slot and the par_err output.
`default_nettype none

module tdm_demux8
  import tdm_demux8_pkg::*;
#(
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din,
  input  logic              sync_in,
  output logic [SLOT_W-1:0] slot,
  output logic [NCH-1:0]    y,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_LIM = 4'(LOSS_CNT);

  state_t         r_state;
  logic [2:0]     r_good;
  logic [2:0]     r_miss;
  logic [NCH-1:0] r_shadow;
  logic [NCH-1:0] w_shadow_nxt;
  logic           w_at0;
  logic           w_wrap;
  logic           w_fault;
  logic           w_to_hunt;
  logic           w_acquire;
  logic           w_cnt_inc;
  logic [3:0]     w_good_inc;
  logic [3:0]     w_miss_inc;

  assign w_at0      = (slot == '0);
  // A fault is a missing marker at slot 0 or a marker anywhere else.
  assign w_fault    = w_at0 ? ~sync_in : sync_in;
  assign w_good_inc = {1'b0, r_good} + 4'd1;
  assign w_miss_inc = {1'b0, r_miss} + 4'd1;
  assign w_acquire  = en & sync_in & (r_state == S_HUNT);
  assign w_cnt_inc  = en & (r_state != S_HUNT);

  always_comb begin
    w_to_hunt = 1'b0;
    if (en && w_fault) begin
      if (r_state == S_CHECK) begin
        w_to_hunt = 1'b1;
      end else if ((r_state == S_LOCKED) && (w_miss_inc >= LOSS_LIM)) begin
        w_to_hunt = 1'b1;
      end
    end
  end

  always_comb begin
    w_shadow_nxt = r_shadow;
`ifdef TDM_DEMUX_PARITY_EN
    if (slot != SLOT_W'(NCH)) begin
      w_shadow_nxt[slot[SELW-1:0]] = din;
    end
`else
    w_shadow_nxt[slot] = din;
`endif
  end

  tdm_slot_counter #(
    .F (FRAME_LEN),
    .W (SLOT_W)
  ) u_slot_counter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_cnt_inc),
    .i_clr   (w_to_hunt),
    .i_load1 (w_acquire),
    .o_cnt   (slot),
    .o_wrap  (w_wrap)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (en) begin
      r_par <= w_at0 ? din : (r_par ^ din);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_good      <= '0;
      r_miss      <= '0;
      r_shadow    <= '0;
      y           <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err     <= 1'b0;
`endif
      if (en) begin
        case (r_state)
          S_HUNT: begin
            if (sync_in) begin
              r_shadow <= w_shadow_nxt;
              r_good   <= 3'd1;
              r_miss   <= '0;
              if (LOCK_LIM == 4'd1) begin
                r_state <= S_LOCKED;
                locked  <= 1'b1;
              end else begin
                r_state <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            r_shadow <= w_shadow_nxt;
            if (w_fault) begin
              sync_err <= 1'b1;
              r_state  <= S_HUNT;
              r_good   <= '0;
            end else if (w_at0) begin
              r_good <= w_good_inc[2:0];
              if (w_good_inc >= LOCK_LIM) begin
                r_state <= S_LOCKED;
                locked  <= 1'b1;
                r_miss  <= '0;
              end
            end
          end
          S_LOCKED: begin
            r_shadow <= w_shadow_nxt;
            if (w_fault) begin
              sync_err <= 1'b1;
              if (w_to_hunt) begin
                r_state <= S_HUNT;
                locked  <= 1'b0;
                r_miss  <= '0;
                r_good  <= '0;
              end else begin
                r_miss <= w_miss_inc[2:0];
              end
            end else if (w_at0) begin
              r_miss <= '0;
            end
            // Frame completion is independent of the sync bookkeeping above.
            if (w_wrap) begin
`ifdef TDM_DEMUX_PARITY_EN
              if (r_par ^ din) begin
                par_err <= 1'b1;
              end else begin
                y           <= w_shadow_nxt;
                frame_valid <= 1'b1;
              end
`else
              y           <= w_shadow_nxt;
              frame_valid <= 1'b1;
`endif
            end
          end
          default: begin
            r_state <= S_HUNT;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: directed + randomized stimulus against a frame-level reference model.
`default_nettype none

module tb_tdm_demux8;
  import tdm_demux8_pkg::*;

  localparam int LOCK_N = 2;
  localparam int LOSS_N = 2;
  localparam int M_HUNT = 0;
  localparam int M_CHECK = 1;
  localparam int M_LOCK = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              din;
  logic              sync_in;
  logic [SLOT_W-1:0] slot;
  logic [NCH-1:0]    y;
  logic              frame_valid;
  logic              locked;
  logic              sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic              par_err;
`endif

  tdm_demux8 #(
    .LOCK_CNT (LOCK_N),
    .LOSS_CNT (LOSS_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .sync_in     (sync_in),
    .slot        (slot),
    .y           (y),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .par_err     (par_err)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks receiver mode, position in frame and the received frame bits.
  int       m_mode;
  int       m_pos;
  int       m_good;
  int       m_miss;
  bit       m_frame[FRAME_LEN];
  bit [7:0] m_y;
  bit       m_fv;
  bit       m_se;
  bit       m_pe;

  task automatic model_reset();
    m_mode = M_HUNT;
    m_pos  = 0;
    m_good = 0;
    m_miss = 0;
    m_y    = '0;
    m_fv   = 0;
    m_se   = 0;
    m_pe   = 0;
  endtask

  task automatic model_edge(input bit e, input bit d, input bit s);
    bit       fault;
    bit       hunt;
    bit [7:0] word;
    m_fv = 0;
    m_se = 0;
    m_pe = 0;
    if (!e) return;
    if (m_mode == M_HUNT) begin
      if (s) begin
        m_frame[0] = d;
        m_pos  = 1;
        m_good = 1;
        m_miss = 0;
        m_mode = (LOCK_N == 1) ? M_LOCK : M_CHECK;
      end
      return;
    end
    m_frame[m_pos] = d;
    fault = (m_pos == 0) ? !s : s;
    if (m_mode == M_LOCK && m_pos == FRAME_LEN - 1) begin
      word = '0;
      for (int k = 0; k < NCH; k++) word[k] = m_frame[k];
`ifdef TDM_DEMUX_PARITY_EN
      if ((($countones(word) + int'(m_frame[NCH])) % 2) == 0) begin
        m_y  = word;
        m_fv = 1;
      end else begin
        m_pe = 1;
      end
`else
      m_y  = word;
      m_fv = 1;
`endif
    end
    hunt = 0;
    if (m_mode == M_CHECK) begin
      if (fault) begin
        m_se = 1;
        hunt = 1;
      end else if (m_pos == 0) begin
        m_good++;
        if (m_good >= LOCK_N) begin
          m_mode = M_LOCK;
          m_miss = 0;
        end
      end
    end else begin
      if (fault) begin
        m_se = 1;
        m_miss++;
        if (m_miss >= LOSS_N) hunt = 1;
      end else if (m_pos == 0) begin
        m_miss = 0;
      end
    end
    if (hunt) begin
      m_mode = M_HUNT;
      m_pos  = 0;
      m_good = 0;
      m_miss = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME_LEN;
    end
  endtask

  task automatic compare_all();
    check_val("slot", 32'(slot), 32'(m_pos));
    check_val("y", 32'(y), 32'(m_y));
    check_val("frame_valid", 32'(frame_valid), 32'(m_fv));
    check_val("locked", 32'(locked), 32'(m_mode == M_LOCK));
    check_val("sync_err", 32'(sync_err), 32'(m_se));
`ifdef TDM_DEMUX_PARITY_EN
    check_val("par_err", 32'(par_err), 32'(m_pe));
`endif
  endtask

  task automatic step(input bit e, input bit d, input bit s);
    en      = e;
    din     = d;
    sync_in = s;
    @(posedge clk);
    model_edge(e, d, s);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] data, input bit with_sync, input bit gate, input bit bad_par);
    bit b;
    for (int k = 0; k < FRAME_LEN; k++) begin
      b = (k < NCH) ? data[k] : ((^data) ^ bad_par);
      step(1'b1, b, with_sync && (k == 0));
      if (gate) step(1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_val("rst_slot", 32'(slot), 32'd0);
    check_val("rst_y", 32'(y), 32'd0);
    check_val("rst_locked", 32'(locked), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int tx_pos;
  bit e_r;
  bit s_r;

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    din     = 1'b0;
    sync_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compare_all();

    // Lock acquisition with continuous strobes.
    repeat (4) send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_val("lock_y", 32'(y), 32'h0A5);
    check_val("lock_locked", 32'(locked), 32'd1);

    // Gated strobes.
    repeat (3) send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check_val("gated_y", 32'(y), 32'h03C);

    // Single missed sync keeps lock, two consecutive drop it.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check_val("miss1_locked", 32'(locked), 32'd1);
    check_val("miss1_y", 32'(y), 32'h05A);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    check_val("loss_locked", 32'(locked), 32'd0);
    check_val("loss_y", 32'(y), 32'h096);

    // Misplaced sync while checking.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_val("misplaced_slot", 32'(slot), 32'd0);
    check_val("misplaced_locked", 32'(locked), 32'd0);

    // Async reset mid-frame.
    repeat (3) send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    async_reset();

`ifdef TDM_DEMUX_PARITY_EN
    repeat (3) send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    check_val("par_ok_y", 32'(y), 32'h00F);
    send_frame(8'hF1, 1'b1, 1'b0, 1'b1);
    check_val("par_bad_y", 32'(y), 32'h00F);
    check_val("par_bad_locked", 32'(locked), 32'd1);
`endif

    // Randomized traffic with occasional sync faults and resets.
    tx_pos = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end
      e_r = ($urandom_range(0, 3) != 0);
      s_r = (tx_pos == 0);
      if ($urandom_range(0, 39) == 0) s_r = !s_r;
      step(e_r, 1'($urandom), s_r);
      if (e_r) tx_pos = (tx_pos + 1) % FRAME_LEN;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
